ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
Instruction prefetch queue between the fetch (PC) stage and decode. It captures each instruction returned by instruction memory together with its PC, buffers up to DEPTH entries in a show-ahead FIFO, and presents the head entry to decode. It produces the PC-advance enable for the fetch stage. Redirects (branch/jump/jr) flush it, and a fetched HALT word stops further prefetch.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops prefetch

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  imem returns a valid word this cycle
imemload  input  32  instruction word from imem
imemaddr  input  32  PC of the word on imemload (current fetch PC)
flush  input  1  redirect from a resolved branch/jump/jr; discard all prefetched work
deq  input  1  decode consumes the head entry this cycle
pcen  output  1  fetch PC advance/load enable
valid_out  output  1  head entry valid
instr_out  output  32  head instruction
pc_out  output  32  head instruction PC
npc_out  output  32  pc_out + 4, modulo 2^32
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  clog2(DEPTH)+1  number of occupied entries
halted  output  1  HALT_WORD has been enqueued; prefetch stopped

Behaviour:
- Reset is asynchronous (nRST low): head/tail pointers = 0, count = 0, halted = 0, all storage = 0. Outputs: valid_out = 0, instr_out = 0, pc_out = 0, npc_out = 4, full = 0, empty = 1, pcen = 0.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Storage is a circular buffer of {instr, pc}. Head entry drives instr_out/pc_out combinationally from registered storage (show-ahead, 0-cycle read latency).
- valid_out = ~empty. npc_out = pc_out + 4, truncated to 32 bits (32'hFFFFFFFC -> 0).
- enq = ihit & ~full & ~halted & ~flush. On enq, {imemload, imemaddr} is written at the tail and tail increments mod DEPTH.
- deq_eff = deq & ~empty & ~flush. On deq_eff, head increments mod DEPTH. deq while empty is ignored; count never underflows.
- Count update: enq only +1; deq_eff only -1; both together, count unchanged and the head advances while the tail writes.
- Full blocks enqueue even if deq is asserted in the same cycle (no write-through-when-full).
- Enqueue while empty: the entry is visible on valid_out in the next cycle (1-cycle fill latency). No bypass.
- pcen = flush | enq (combinational). Fetch advances exactly once per accepted word, and loads its redirect target on flush.
- halted: set on the clock edge where enq occurs with imemload == HALT_WORD. While halted, no enqueue occurs and pcen = flush. The HALT entry itself is still enqueued and drains normally.
- flush (synchronous): at the next edge, head = tail = 0, count = 0, halted = 0. Any word on imemload that cycle is discarded. flush overrides enq and deq in the same cycle, and overrides a HALT_WORD arriving in the same cycle.
- Pointer width is clog2(DEPTH). Wrap-around is implicit in the power-of-two modulus.

Test Plan:
- Reset then ihit=1 with words 0x2001000A @0x0, 0x20020005 @0x4, deq=0 -> count 1 then 2; pc_out=0x0; instr_out=0x2001000A; npc_out=0x4; pcen=1 both cycles.
- Fill to DEPTH=4 with deq=0 and ihit held high -> full=1, pcen=0. Assert deq with ihit=1 -> count 3 next cycle; no write that cycle; head advances to pc 0x4.
- Steady stream with simultaneous enq and deq at count=2 over 10 cycles -> count stays 2; head PCs sequence 0x0,0x4,...; pointers wrap through index 3 -> 0 with no lost or duplicated entry.
- Queue holds 3 entries, flush=1 with ihit=1 and imemload=0x08000010 -> pcen=1 that cycle; next cycle empty=1, valid_out=0, count=0; the word is not enqueued.
- Enqueue 0xFFFFFFFF @0x20 -> halted=1; further ihit produces no enqueue and pcen=0; HALT drains with pc_out=0x20. A later flush clears halted and re-enables pcen on ihit.
- Assert nRST low asynchronously mid-stream with count=3 -> count=0, valid_out=0, instr_out=0, npc_out=4 before the next clock edge. An entry at pc_out=0xFFFFFFFC gives npc_out=0x0.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction prefetch queue between fetch and decode.
//
// Captures each word returned by instruction memory together with its PC in a
// show-ahead circular FIFO and presents the head entry to decode with zero
// read latency. Produces the fetch PC-advance enable. A flush (redirect)
// empties the queue; enqueueing HALT_WORD stops further prefetch until flushed.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   ihit                 imem returns a valid word this cycle
//   imemload, imemaddr   returned word and its PC
//   flush                redirect: discard all prefetched work
//   deq                  decode consumes the head entry
//   pcen                 fetch PC advance / redirect-load enable
//   valid_out            head entry valid
//   instr_out, pc_out    head instruction and its PC
//   npc_out              pc_out + 4 (mod 2^32)
//   full, empty, count   occupancy status
//   halted               HALT_WORD enqueued; prefetch stopped
module ifetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ihit,
  input  logic [31:0]                imemload,
  input  logic [31:0]                imemaddr,
  input  logic                       flush,
  input  logic                       deq,
  output logic                       pcen,
  output logic                       valid_out,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic [31:0]                npc_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          halted_reg, halted_next;

  logic          enq;
  logic          deq_eff;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // flush wins over both sides of the queue in the same cycle.
  assign enq     = ihit & ~full & ~halted_reg & ~flush;
  assign deq_eff = deq & ~empty & ~flush;

  assign pcen = flush | enq;

  always_comb begin
    head_next   = head_reg;
    tail_next   = tail_reg;
    count_next  = count_reg;
    halted_next = halted_reg;
    if (flush) begin
      head_next   = '0;
      tail_next   = '0;
      count_next  = '0;
      halted_next = 1'b0;
    end else begin
      // Pointer wrap is implicit in the power-of-two width.
      if (enq)     tail_next = tail_reg + PW'(1);
      if (deq_eff) head_next = head_reg + PW'(1);
      case ({enq, deq_eff})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
      if (enq && (imemload == HALT_WORD)) halted_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      halted_reg <= 1'b0;
    end else begin
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      count_reg  <= count_next;
      halted_reg <= halted_next;
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (enq) begin
      instr_mem[tail_reg] <= imemload;
      pc_mem[tail_reg]    <= imemaddr;
    end
  end

  // Show-ahead read: head entry straight from registered storage, no bypass.
  assign instr_out = instr_mem[head_reg];
  assign pc_out    = pc_mem[head_reg];
  assign npc_out   = pc_out + 32'd4;
  assign valid_out = ~empty;
  assign count     = count_reg;
  assign halted    = halted_reg;

endmodule
